// File: rtl/compute_unit_pkg.sv
`default_nettype none
//============================================================================
// Module   : compute_unit_pkg
// Purpose  : Shared widths, opcode map and sequencer FSM encoding for the
//            16-bit-instruction compute unit front end.
// Contents : INSTR_W, DATA_W, OP_* opcodes, OP_MAX, S_* state encoding,
//            opcode_legal() helper.
// Revision : 1.0 - initial release
//============================================================================
package compute_unit_pkg;

   localparam int INSTR_W = 16;
   localparam int DATA_W  = 8;

   // Opcode map: upper nibble of the instruction
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_MOV = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_MAX = OP_XOR;

   // Issue FSM encoding
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   function automatic logic opcode_legal(input logic [3:0] op);
      return (op <= OP_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/compute_unit_sequencer_fifo.sv
`default_nettype none
//============================================================================
// Module   : instr_fifo
// Purpose  : Synchronous FIFO holding assembled instructions.
// Ports    : clk, rst_n (async active-low), flush (sync clear),
//            push/din (write), pop/dout (head read, first-word fall-through),
//            full, empty, count (entries held).
// Revision : 1.0 - initial release
//============================================================================
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage carries no reset; only pointers/count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_count == CNT_W'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/compute_unit_sequencer.sv
`default_nettype none
//============================================================================
// Module   : compute_unit_sequencer
// Purpose  : Front end of the compute unit. Pairs stream bytes into 16-bit
//            instructions, queues them, issues one at a time over a
//            valid/ready handshake and captures the result after a fixed
//            latency. One instruction in flight removes RAW hazards.
// Ports    : clk, rst_n (async active-low), ena (global freeze), flush;
//            byte_in/byte_valid/byte_ready (instruction stream);
//            issue_instr/issue_valid/issue_ready (to compute unit);
//            result_in (from unit), result_out/result_valid (captured);
//            fifo_count, busy, err_opcode (status).
// Revision : 1.0 - initial release
//============================================================================
module compute_unit_sequencer
   import compute_unit_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int RESULT_LAT = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            ena,
   input  logic                            flush,
   input  logic [DATA_W-1:0]               byte_in,
   input  logic                            byte_valid,
   output logic                            byte_ready,
   output logic [INSTR_W-1:0]              issue_instr,
   output logic                            issue_valid,
   input  logic                            issue_ready,
   input  logic [DATA_W-1:0]               result_in,
   output logic [DATA_W-1:0]               result_out,
   output logic                            result_valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic                            busy,
   output logic                            err_opcode
);

   localparam int LAT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
   localparam logic [LAT_W-1:0] C_LAT_RELOAD = LAT_W'(RESULT_LAT - 1);

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [LAT_W-1:0]   r_lat_cnt;
   logic [DATA_W-1:0]  r_hi_byte;
   logic               r_hi_pending;
   logic               r_err;
   logic [DATA_W-1:0]  r_result;
   logic               r_result_valid;

   logic               w_flush;
   logic               w_byte_acc;
   logic               w_push;
   logic               w_issue_hs;
   logic               w_lat_done;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic [INSTR_W-1:0] w_fifo_head;
   logic [INSTR_W-1:0] w_instr;

   assign w_flush    = ena & flush;
   assign byte_ready = ena & ~flush & ~w_fifo_full;
   assign w_byte_acc = byte_valid & byte_ready;
   assign w_instr    = {r_hi_byte, byte_in};
   // Completed instructions with an illegal opcode are dropped, not queued.
   assign w_push     = w_byte_acc & r_hi_pending & opcode_legal(r_hi_byte[7:4]);
   assign w_issue_hs = issue_valid & issue_ready;
   assign w_lat_done = (r_state == S_WAIT) && (r_lat_cnt == '0);

   instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (w_flush),
      .push  (w_push),
      .din   (w_instr),
      .pop   (w_issue_hs),
      .dout  (w_fifo_head),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (fifo_count)
   );

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      if (w_flush) begin
         w_state_nxt = S_IDLE;
      end else if (ena) begin
         case (r_state)
            S_IDLE:  if (!w_fifo_empty) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_issue_hs)    w_state_nxt = S_WAIT;
            S_WAIT:  if (r_lat_cnt == '0) w_state_nxt = w_fifo_empty ? S_IDLE : S_ISSUE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // FSM: outputs. issue_valid is withheld during a flush cycle so the unit
   // never accepts an instruction whose result would be discarded.
   always_comb begin
      issue_valid = ena & ~flush & (r_state == S_ISSUE);
      issue_instr = (r_state == S_ISSUE) ? w_fifo_head : '0;
      busy        = (r_state != S_IDLE) | (fifo_count != '0) | r_hi_pending;
   end

   // Assembler, latency counter, result capture and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi_byte      <= '0;
         r_hi_pending   <= 1'b0;
         r_err          <= 1'b0;
         r_lat_cnt      <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
      end else if (ena) begin
         r_result_valid <= 1'b0;
         if (w_flush) begin
            r_hi_pending <= 1'b0;
            r_err        <= 1'b0;
            r_lat_cnt    <= '0;
         end else begin
            if (w_byte_acc) begin
               if (!r_hi_pending) begin
                  r_hi_byte    <= byte_in;
                  r_hi_pending <= 1'b1;
               end else begin
                  r_hi_pending <= 1'b0;
                  if (!opcode_legal(r_hi_byte[7:4])) r_err <= 1'b1;
               end
            end
            if (w_issue_hs) begin
               r_lat_cnt <= C_LAT_RELOAD;
            end else if ((r_state == S_WAIT) && (r_lat_cnt != '0)) begin
               r_lat_cnt <= r_lat_cnt - 1'b1;
            end
            if (w_lat_done) begin
               r_result       <= result_in;
               r_result_valid <= 1'b1;
            end
         end
      end
   end

   assign result_out   = r_result;
   assign result_valid = r_result_valid;
   assign err_opcode   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_compute_unit_sequencer.sv
`default_nettype none
//============================================================================
// Module   : tb_compute_unit_sequencer
// Purpose  : Self-checking bench for compute_unit_sequencer. A transaction
//            model (instruction queue, in-flight latency, expected result)
//            tracks the stream and is compared against the DUT each cycle;
//            directed scenario tasks add exact-timing checks.
// Revision : 1.0 - initial release
//============================================================================
module tb_compute_unit_sequencer;

   localparam int FIFO_DEPTH = 4;
   localparam int RESULT_LAT = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        flush = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic [15:0] issue_instr;
   logic        issue_valid;
   logic        issue_ready = 1'b0;
   logic [7:0]  result_in = 8'h00;
   logic [7:0]  result_out;
   logic        result_valid;
   logic [2:0]  fifo_count;
   logic        busy;
   logic        err_opcode;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   compute_unit_sequencer #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .RESULT_LAT (RESULT_LAT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .flush        (flush),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .issue_instr  (issue_instr),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .result_in    (result_in),
      .result_out   (result_out),
      .result_valid (result_valid),
      .fifo_count   (fifo_count),
      .busy         (busy),
      .err_opcode   (err_opcode)
   );

   // Compute-unit result source: random unless a test pins it.
   bit         res_fix_en = 1'b0;
   logic [7:0] res_fix = 8'h00;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         result_in = res_fix_en ? res_fix : 8'($urandom);
      end
   end

   // Reference model state
   logic [15:0] m_q[$];
   bit          m_half;
   logic [7:0]  m_hi;
   bit          m_err;
   int          m_wait;
   bit          m_rv_due;
   logic [7:0]  m_res;
   logic [7:0]  m_out;
   int          m_stall;
   int          hs_total = 0;

   // Per-cycle monitor: compare DUT against model, then advance the model
   // by what happens at the coming edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_q.delete();
            m_half = 0; m_err = 0; m_wait = 0; m_rv_due = 0;
            m_out = 8'h00; m_stall = 0;
            continue;
         end
         checks++;
         if (result_valid !== m_rv_due) begin
            errors++;
            $display("FAIL mon_result_valid got %0b exp %0b at %0t", result_valid, m_rv_due, $time);
         end
         if (m_rv_due) m_out = m_res;
         m_rv_due = 0;
         checks++;
         if (result_out !== m_out) begin
            errors++;
            $display("FAIL mon_result_out got %02h exp %02h at %0t", result_out, m_out, $time);
         end
         checks++;
         if (fifo_count !== 3'(m_q.size())) begin
            errors++;
            $display("FAIL mon_fifo_count got %0d exp %0d at %0t", fifo_count, m_q.size(), $time);
         end
         checks++;
         if (err_opcode !== m_err) begin
            errors++;
            $display("FAIL mon_err_opcode got %0b exp %0b at %0t", err_opcode, m_err, $time);
         end
         checks++;
         if (busy !== ((m_q.size() != 0) || m_half || (m_wait > 0))) begin
            errors++;
            $display("FAIL mon_busy got %0b at %0t", busy, $time);
         end
         checks++;
         if (byte_ready !== (ena && !flush && (m_q.size() < FIFO_DEPTH))) begin
            errors++;
            $display("FAIL mon_byte_ready got %0b at %0t", byte_ready, $time);
         end
         if (issue_valid) begin
            checks++;
            if (!ena || flush || m_q.size() == 0 || m_wait > 0) begin
               errors++;
               $display("FAIL mon_issue_valid got 1 exp 0 (qsize %0d inflight %0d) at %0t", m_q.size(), m_wait, $time);
            end else if (issue_instr !== m_q[0]) begin
               errors++;
               $display("FAIL mon_issue_instr got %04h exp %04h at %0t", issue_instr, m_q[0], $time);
            end
         end
         if (ena && !flush && m_q.size() != 0 && m_wait == 0 && !issue_valid) m_stall++;
         else m_stall = 0;
         checks++;
         if (m_stall > 1) begin
            errors++;
            $display("FAIL mon_issue_stall got %0d idle cycles exp <=1 at %0t", m_stall, $time);
         end
         if (!ena) continue;
         if (flush) begin
            m_q.delete();
            m_half = 0; m_err = 0; m_wait = 0; m_rv_due = 0;
            continue;
         end
         if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
               m_res = result_in;
               m_rv_due = 1;
            end
         end
         if (issue_valid && issue_ready && m_q.size() != 0) begin
            void'(m_q.pop_front());
            m_wait = RESULT_LAT;
            hs_total++;
         end
         if (byte_valid && byte_ready) begin
            if (!m_half) begin
               m_half = 1;
               m_hi = byte_in;
            end else begin
               m_half = 0;
               if (m_hi[7:4] > 4'h7) m_err = 1;
               else m_q.push_back({m_hi, byte_in});
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one byte and hold it until accepted (bounded).
   task automatic send_byte(input logic [7:0] b);
      bit done = 0;
      byte_valid = 1'b1;
      byte_in = b;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = byte_ready;
         @(posedge clk);
         #1;
      end
      byte_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_byte_timeout byte %02h got no accept exp accept", b);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      ena = 1'b0;
      tick(5);
      checks++;
      if ({issue_valid, result_valid, busy, err_opcode, byte_ready} !== 5'b0 ||
          issue_instr !== 16'h0 || result_out !== 8'h0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL reset_outputs got iv%0b rv%0b busy%0b err%0b br%0b instr%04h out%02h cnt%0d exp all 0",
                  issue_valid, result_valid, busy, err_opcode, byte_ready, issue_instr, result_out, fifo_count);
      end
      rst_n = 1'b1;
      tick();
      ena = 1'b1;
      #1;
      checks++;
      if (byte_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_byte_ready got %0b exp 1", byte_ready);
      end
      tick();
   endtask

   task automatic test_single;
      res_fix_en = 1'b1;
      res_fix = 8'h2A;
      issue_ready = 1'b1;
      send_byte(8'h11);
      send_byte(8'h2A);
      checks++;
      if (issue_valid !== 1'b0 || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL single_queued got iv%0b cnt%0d exp iv0 cnt1", issue_valid, fifo_count);
      end
      tick();
      checks++;
      if (issue_valid !== 1'b1 || issue_instr !== 16'h112A) begin
         errors++;
         $display("FAIL single_issue got iv%0b instr%04h exp iv1 instr112a", issue_valid, issue_instr);
      end
      tick();
      checks++;
      if (issue_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_wait_iv got %0b exp 0", issue_valid);
      end
      tick();
      checks++;
      if (result_valid !== 1'b1 || result_out !== 8'h2A) begin
         errors++;
         $display("FAIL single_result got rv%0b out%02h exp rv1 out2a", result_valid, result_out);
      end
      tick();
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse got rv%0b busy%0b exp rv0 busy0", result_valid, busy);
      end
      res_fix_en = 1'b0;
   endtask

   task automatic test_fill;
      logic [15:0] prog [4] = '{16'h1105, 16'h1203, 16'h2312, 16'h3412};
      int h0 = hs_total;
      bit drained = 0;
      issue_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_byte(prog[i][15:8]);
         send_byte(prog[i][7:0]);
      end
      checks++;
      if (fifo_count !== 3'd4 || byte_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_full got cnt%0d br%0b exp cnt4 br0", fifo_count, byte_ready);
      end
      issue_ready = 1'b1;
      for (int i = 0; i < 100 && !drained; i++) begin
         tick();
         drained = !busy;
      end
      checks++;
      if (!drained || fifo_count !== 3'd0 || hs_total - h0 != 4) begin
         errors++;
         $display("FAIL fill_drain got cnt%0d issued%0d exp cnt0 issued4", fifo_count, hs_total - h0);
      end
   endtask

   task automatic test_illegal;
      int h0 = hs_total;
      send_byte(8'h9F);
      send_byte(8'h00);
      tick(2);
      checks++;
      if (err_opcode !== 1'b1 || fifo_count !== 3'd0 || hs_total != h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL illegal_flag got err%0b cnt%0d issued%0d busy%0b exp err1 cnt0 issued0 busy0",
                  err_opcode, fifo_count, hs_total - h0, busy);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (err_opcode !== 1'b0) begin
         errors++;
         $display("FAIL illegal_flush_clear got %0b exp 0", err_opcode);
      end
   endtask

   task automatic test_flush_wait;
      bit seen = 0;
      logic [7:0] prev_out;
      issue_ready = 1'b0;
      send_byte(8'h11); send_byte(8'h01);
      send_byte(8'h22); send_byte(8'h02);
      send_byte(8'h33); send_byte(8'h03);
      issue_ready = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = issue_valid && issue_ready;
         @(posedge clk);
         #1;
      end
      issue_ready = 1'b0;
      prev_out = result_out;
      checks++;
      if (!seen || fifo_count !== 3'd2) begin
         errors++;
         $display("FAIL flushwait_setup got seen%0b cnt%0d exp seen1 cnt2", seen, fifo_count);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (fifo_count !== 3'd0 || busy !== 1'b0 || result_valid !== 1'b0 || result_out !== prev_out) begin
         errors++;
         $display("FAIL flushwait_after got cnt%0d busy%0b rv%0b out%02h exp cnt0 busy0 rv0 out%02h",
                  fifo_count, busy, result_valid, result_out, prev_out);
      end
      tick();
      checks++;
      if (result_valid !== 1'b0 || issue_valid !== 1'b0) begin
         errors++;
         $display("FAIL flushwait_quiet got rv%0b iv%0b exp 0 0", result_valid, issue_valid);
      end
   endtask

   task automatic test_enable;
      ena = 1'b0;
      byte_valid = 1'b1;
      byte_in = 8'h12;
      tick(3);
      checks++;
      if (byte_ready !== 1'b0 || fifo_count !== 3'd0 || issue_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL enable_freeze got br%0b cnt%0d iv%0b busy%0b exp all 0", byte_ready, fifo_count, issue_valid, busy);
      end
      byte_valid = 1'b0;
      ena = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid;
      bit seen = 0;
      issue_ready = 1'b0;
      send_byte(8'h44);
      send_byte(8'h55);
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = issue_valid;
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (!seen || issue_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got seen%0b iv%0b cnt%0d busy%0b rv%0b exp seen1 rest 0",
                  seen, issue_valid, fifo_count, busy, result_valid);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random;
      int h0 = hs_total;
      for (int c = 0; c < 600; c++) begin
         byte_valid = ($urandom % 4) != 0;
         byte_in = 8'($urandom);
         if ($urandom % 8 != 0) byte_in[7] = 1'b0;
         issue_ready = ($urandom % 3) != 0;
         flush = ($urandom % 64) == 0;
         tick();
      end
      byte_valid = 1'b0;
      flush = 1'b0;
      issue_ready = 1'b1;
      tick(12);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || hs_total - h0 < 20) begin
         errors++;
         $display("FAIL random_end got busy%0b issued%0d exp busy0 issued>=20", busy, hs_total - h0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_illegal();
      test_flush_wait();
      test_enable();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
